// File: rtl/instr_encoder.sv
// Field-level instruction request packer with a small first-word-fall-through
// output FIFO; illegal function codes are rejected and counted.
module instr_encoder #(
  parameter int DWIDTH = 32,
  parameter int RWIDTH = 6,
  parameter int IMM_IN = 15,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_ri,
  input  logic [RWIDTH-1:0]          in_rs,
  input  logic [RWIDTH-1:0]          in_rd,
  input  logic [3:0]                 in_fx,
  input  logic [RWIDTH-1:0]          in_rt,
  input  logic [IMM_IN-1:0]          in_imm,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DWIDTH-1:0]          out_data,
  output logic                       out_ld,
  output logic                       out_st,
  output logic                       err,
  output logic [$clog2(DEPTH):0]     level,
  output logic [7:0]                 err_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_ZERO = LW'(0);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  function automatic logic fx_legal(input logic [3:0] fx);
    case (fx)
      4'b0000, 4'b0011, 4'b1000, 4'b1001, 4'b1011, 4'b1010,
      4'b1101, 4'b0010, 4'b0100, 4'b0110, 4'b1111: fx_legal = 1'b1;
      default:                                     fx_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [DWIDTH-1:0] encode(
    input logic              ri,
    input logic [RWIDTH-1:0] rs,
    input logic [RWIDTH-1:0] rd,
    input logic [3:0]        fx,
    input logic [RWIDTH-1:0] rt,
    input logic [IMM_IN-1:0] imm
  );
    if (ri) begin
      encode = {1'b1, rs, rd, fx, imm};
    end else begin
      encode = {1'b0, rs, rd, fx, rt, imm[8:0]};
    end
  endfunction

  logic [DWIDTH-1:0] mem_r [DEPTH];
  logic              ld_mem_r [DEPTH];
  logic              st_mem_r [DEPTH];
  logic [AW-1:0]     wptr_r, rptr_r;
  logic [LW-1:0]     level_r;
  logic              in_ready_r, out_valid_r, out_ld_r, out_st_r, err_r;
  logic [DWIDTH-1:0] out_data_r;
  logic [7:0]        err_count_r;

  logic              accept_s, push_s, pop_s, reject_s;
  logic              word_ld_s, word_st_s, head_ld_s, head_st_s;
  logic [DWIDTH-1:0] word_s, head_s;
  logic [LW-1:0]     level_nxt_s, level_after_pop_s;
  logic [AW-1:0]     rptr_nxt_s;

  // Handshake decode, next occupancy and the head word visible after this edge
  always_comb begin
    accept_s          = in_valid && in_ready_r;
    push_s            = accept_s && fx_legal(in_fx);
    reject_s          = accept_s && !fx_legal(in_fx);
    pop_s             = out_valid_r && out_ready;
    word_s            = encode(in_ri, in_rs, in_rd, in_fx, in_rt, in_imm);
    word_ld_s         = (in_fx == 4'b0100);
    word_st_s         = (in_fx == 4'b0110);
    level_after_pop_s = level_r - LW'(pop_s);
    level_nxt_s       = level_after_pop_s + LW'(push_s);
    rptr_nxt_s        = pop_s ? (rptr_r + PTR_ONE) : rptr_r;
    head_s            = {DWIDTH{1'b0}};
    head_ld_s         = 1'b0;
    head_st_s         = 1'b0;
    if (level_nxt_s == LVL_ZERO) begin
      head_s    = {DWIDTH{1'b0}};
      head_ld_s = 1'b0;
      head_st_s = 1'b0;
    end else if (push_s && (level_after_pop_s == LVL_ZERO)) begin
      // The FIFO drains and refills in one edge: the incoming word becomes head
      head_s    = word_s;
      head_ld_s = word_ld_s;
      head_st_s = word_st_s;
    end else begin
      head_s    = mem_r[rptr_nxt_s];
      head_ld_s = ld_mem_r[rptr_nxt_s];
      head_st_s = st_mem_r[rptr_nxt_s];
    end
  end

  // FIFO storage write port
  always_ff @(posedge clk) begin
    if (push_s && !rst) begin
      mem_r[wptr_r]    <= word_s;
      ld_mem_r[wptr_r] <= word_ld_s;
      st_mem_r[wptr_r] <= word_st_s;
    end
  end

  // Pointers, occupancy, registered outputs and reject accounting
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_r      <= {AW{1'b0}};
      rptr_r      <= {AW{1'b0}};
      level_r     <= LVL_ZERO;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_data_r  <= {DWIDTH{1'b0}};
      out_ld_r    <= 1'b0;
      out_st_r    <= 1'b0;
      err_r       <= 1'b0;
      err_count_r <= 8'd0;
    end else begin
      if (push_s) begin
        wptr_r <= wptr_r + PTR_ONE;
      end
      rptr_r      <= rptr_nxt_s;
      level_r     <= level_nxt_s;
      in_ready_r  <= (level_nxt_s < LVL_FULL);
      out_valid_r <= (level_nxt_s != LVL_ZERO);
      out_data_r  <= head_s;
      out_ld_r    <= head_ld_s;
      out_st_r    <= head_st_s;
      err_r       <= reject_s;
      if (reject_s && (err_count_r != 8'hFF)) begin
        err_count_r <= err_count_r + 8'd1;
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_ld    = out_ld_r;
  assign out_st    = out_st_r;
  assign err       = err_r;
  assign level     = level_r;
  assign err_count = err_count_r;

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized bench for instr_encoder: a queue-based reference model is compared
// with the DUT every cycle, plus hand-computed literal checks.
module tb_instr_encoder;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_ri, out_valid, out_ready, out_ld, out_st, err;
  logic [5:0]  in_rs, in_rd, in_rt;
  logic [3:0]  in_fx;
  logic [14:0] in_imm;
  logic [31:0] out_data;
  logic [2:0]  level;
  logic [7:0]  err_count;

  instr_encoder #(.DWIDTH(32), .RWIDTH(6), .IMM_IN(15), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_ri(in_ri),
    .in_rs(in_rs), .in_rd(in_rd), .in_fx(in_fx), .in_rt(in_rt), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ld(out_ld),
    .out_st(out_st), .err(err), .level(level), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        ld;
    logic        st;
  } ent_t;

  ent_t        mq[$];
  logic        m_err = 1'b0;
  int          m_cnt = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  bit          chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_word(input logic ri, input int rs, input int rd,
                                             input int fx, input int rt, input int imm);
    if (ri) return 32'((1 << 31) + (rs << 25) + (rd << 19) + (fx << 15) + imm);
    return 32'((rs << 25) + (rd << 19) + (fx << 15) + (rt << 9) + (imm % 512));
  endfunction

  // Reference model: advances on every rising edge from the sampled inputs
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_err = 1'b0;
      m_cnt = 0;
    end else begin
      automatic bit acc   = in_valid && (mq.size() < DEPTH);
      automatic bit legal = !(in_fx inside {4'b0001, 4'b0101, 4'b0111, 4'b1100, 4'b1110});
      automatic ent_t e;
      if (mq.size() > 0 && out_ready) void'(mq.pop_front());
      if (acc && legal) begin
        e.d  = model_word(in_ri, in_rs, in_rd, in_fx, in_rt, in_imm);
        e.ld = (in_fx == 4'd4);
        e.st = (in_fx == 4'd6);
        mq.push_back(e);
      end
      m_err = acc && !legal;
      if (acc && !legal && m_cnt < 255) m_cnt++;
    end
  end

  // Per-cycle compare of every output against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
      chk("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
      chk("level", 32'(level), 32'(mq.size()));
      chk("out_data", out_data, (mq.size() != 0) ? mq[0].d : 32'd0);
      chk("out_ld", 32'(out_ld), (mq.size() != 0) ? 32'(mq[0].ld) : 32'd0);
      chk("out_st", 32'(out_st), (mq.size() != 0) ? 32'(mq[0].st) : 32'd0);
      chk("err", 32'(err), 32'(m_err));
      chk("err_count", 32'(err_count), 32'(m_cnt));
    end
  end

  // Drive one cycle of inputs, then wait to the following falling edge
  task automatic req(input logic v, input logic ri, input int rs, input int rd,
                     input int fx, input int rt, input int imm, input logic ordy);
    in_valid  = v;
    in_ri     = ri;
    in_rs     = 6'(rs);
    in_rd     = 6'(rd);
    in_fx     = 4'(fx);
    in_rt     = 6'(rt);
    in_imm    = 15'(imm);
    out_ready = ordy;
    @(negedge clk);
  endtask

  task automatic idle(input logic ordy);
    req(1'b0, 1'b0, 0, 0, 15, 0, 0, ordy);
  endtask

  function automatic int legal_fx();
    int tbl[11] = '{0, 3, 8, 9, 11, 10, 13, 2, 4, 6, 15};
    return tbl[$urandom_range(10, 0)];
  endfunction

  initial begin
    rst = 1'b1;
    idle(1'b0);
    idle(1'b0);
    chk_en = 1'b1;
    rst = 1'b0;
    idle(1'b0);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst level", 32'(level), 32'd0);
    chk("rst err_count", 32'(err_count), 32'd0);
    chk("rst out_data", out_data, 32'd0);

    // I-type: {1, 000011, 000101, 0000, 7FFF}
    req(1'b1, 1'b1, 3, 5, 0, 0, 'h7FFF, 1'b0);
    chk("itype word", out_data, 32'h8628_7FFF);
    chk("itype valid", 32'(out_valid), 32'd1);
    chk("itype ld", 32'(out_ld), 32'd0);
    idle(1'b1);

    // R-type LOAD: {0, 000001, 000010, 0100, 000100, 1FF}
    req(1'b1, 1'b0, 1, 2, 4, 4, 'h1FF, 1'b0);
    chk("rtype word", out_data, 32'h0212_09FF);
    chk("rtype ld", 32'(out_ld), 32'd1);
    idle(1'b1);
    req(1'b1, 1'b0, 1, 2, 4, 4, 'h7FFF, 1'b0);
    chk("rtype imm hi ignored", out_data, 32'h0212_09FF);
    idle(1'b1);

    // Fill under backpressure, then try to push into a full FIFO
    for (int i = 0; i < DEPTH; i++) req(1'b1, 1'b1, i, i + 1, 6, 0, i * 7, 1'b0);
    chk("full in_ready", 32'(in_ready), 32'd0);
    chk("full level", 32'(level), 32'(DEPTH));
    chk("full st", 32'(out_st), 32'd1);
    req(1'b1, 1'b1, 9, 9, 0, 0, 1, 1'b0);
    chk("full refuse", 32'(level), 32'(DEPTH));
    req(1'b1, 1'b1, 9, 9, 0, 0, 2, 1'b1);
    chk("full refuse w/ pop", 32'(level), 32'(DEPTH - 1));
    chk("ready after pop", 32'(in_ready), 32'd1);
    for (int i = 0; i < DEPTH; i++) idle(1'b1);

    // Back-to-back rejects, then saturation
    req(1'b1, 1'b0, 1, 1, 5, 1, 1, 1'b1);
    chk("err 1st", 32'(err), 32'd1);
    req(1'b1, 1'b0, 1, 1, 14, 1, 1, 1'b1);
    chk("err 2nd", 32'(err), 32'd1);
    idle(1'b1);
    chk("err drop", 32'(err), 32'd0);
    chk("err_count 2", 32'(err_count), 32'd2);
    chk("reject no word", 32'(out_valid), 32'd0);
    for (int i = 0; i < 300; i++) req(1'b1, 1'b1, 0, 0, 7, 0, 0, 1'b1);
    idle(1'b1);
    chk("err_count sat", 32'(err_count), 32'd255);

    // Streaming with wrap
    for (int i = 0; i < 3 * DEPTH; i++) begin
      req(1'b1, 1'($urandom_range(1, 0)), $urandom_range(63, 0), $urandom_range(63, 0),
          legal_fx(), $urandom_range(63, 0), $urandom_range(32767, 0), 1'b1);
      chk("stream level<=1", 32'(level <= 3'd1), 32'd1);
    end
    idle(1'b1);

    // Reset with three words buffered
    for (int i = 0; i < 3; i++) req(1'b1, 1'b1, i, 0, 0, 0, i, 1'b0);
    chk("pre-reset level", 32'(level), 32'd3);
    rst = 1'b1;
    req(1'b1, 1'b1, 1, 1, 0, 0, 1, 1'b1);
    rst = 1'b0;
    chk("post-reset level", 32'(level), 32'd0);
    chk("post-reset valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Random traffic including illegal codes and random backpressure
    for (int i = 0; i < 600; i++) begin
      req(1'($urandom_range(3, 0) != 0), 1'($urandom_range(1, 0)), $urandom_range(63, 0),
          $urandom_range(63, 0), ($urandom_range(3, 0) == 0) ? $urandom_range(15, 0) : legal_fx(),
          $urandom_range(63, 0), $urandom_range(32767, 0), 1'($urandom_range(2, 0) != 0));
    end
    for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
